// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time programmable clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      STOP     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

   // Elaboration-time divisor; never below the smallest legal period.
   function automatic logic [31:0] def_div(input int unsigned clk_freq,
                                           input int unsigned out_freq);
      int unsigned d;
      d = (out_freq == 0) ? MIN_DIV : clk_freq / out_freq;
      if (d < MIN_DIV) d = MIN_DIV;
      return d;
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and phase decode; outclock and tick come straight from flops.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int              DIV_W   = 16,
   parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(8)
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             live,
   input  logic             run,
   input  logic             load,
   input  logic [DIV_W-1:0] load_div,
   output logic             outclock,
   output logic             tick
);

   function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
      return d - (d >> 1);
   endfunction

   logic [DIV_W-1:0] cnt, div_q, half_q;
   logic [DIV_W-1:0] cnt_n, div_n, half_n;

   // Outputs are registered from next-state values so they cannot glitch.
   always_comb begin
      div_n  = load ? load_div : div_q;
      half_n = load ? high_len(load_div) : half_q;
      cnt_n  = '0;
      if (run && live && !tick) cnt_n = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         cnt      <= '0;
         div_q    <= DEF_DIV;
         half_q   <= high_len(DEF_DIV);
         outclock <= 1'b0;
         tick     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         div_q    <= div_n;
         half_q   <= half_n;
         outclock <= run && (cnt_n < half_n);
         tick     <= run && (cnt_n == div_n - 1'b1);
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop sequencing and divisor handshake around the period counter.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 2_000_000,
   parameter int unsigned DEF_OUT_FREQ = 250_000,
   parameter int          DIV_W        = 16
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             en,
   input  logic             div_req,
   input  logic [DIV_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic             busy,
   output logic             outclock,
   output logic             tick
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(def_div(CLK_FREQ, DEF_OUT_FREQ));
   localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);

   state_t           state;
   logic [DIV_W-1:0] shadow;
   logic             live, run, load, accept;

   // tick marks the last cycle of a period, i.e. the only place a period may end.
   always_comb begin
      live   = (state != STOP);
      run    = live ? (en || !tick) : en;
      load   = busy && (tick || !live);
      accept = div_req && !busy && !div_ack;
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state   <= STOP;
         shadow  <= '0;
         busy    <= 1'b0;
         div_ack <= 1'b0;
         div_err <= 1'b0;
      end else begin
         case (state)
            STOP:     if (en) state <= RUN;
            RUN:      if (!en) state <= tick ? STOP : STOPPING;
            STOPPING: if (en) state <= RUN;
                      else if (tick) state <= STOP;
            default:  state <= STOP;
         endcase
         div_ack <= accept;
         div_err <= accept && (div_val < MIN_D);
         if (accept && (div_val >= MIN_D)) begin
            shadow <= div_val;
            busy   <= 1'b1;
         end else if (load) begin
            busy   <= 1'b0;
         end
      end
   end

   clk_div_core #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
   ) u_core (
      .clk      (clk),
      .aclr     (aclr),
      .live     (live),
      .run      (run),
      .load     (load),
      .load_div (shadow),
      .outclock (outclock),
      .tick     (tick)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: period-level reference model feeding a per-cycle scoreboard.
module tb_clk_div_ctrl;

   logic        clk = 1'b0;
   logic        aclr = 1'b0;
   logic        en = 1'b0;
   logic        div_req = 1'b0;
   logic [15:0] div_val = '0;
   logic        div_ack, div_err, busy, outclock, tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic oc;
      logic tk;
      logic ack;
      logic err;
      logic bsy;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .CLK_FREQ     (2_000_000),
      .DEF_OUT_FREQ (250_000),
      .DIV_W        (16)
   ) dut (
      .clk      (clk),
      .aclr     (aclr),
      .en       (en),
      .div_req  (div_req),
      .div_val  (div_val),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .busy     (busy),
      .outclock (outclock),
      .tick     (tick)
   );

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0b expected %0b at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: pos is the position inside the running period, -1 when idle.
   // A period always runs to its end; at the end it continues only if en is high.
   initial begin : model
      int   pos, d, pend, npos;
      bit   mbusy, mack, last, apply, accept;
      exp_t e;
      pos = -1; d = 8; pend = 0; mbusy = 0; mack = 0;
      forever begin
         @(posedge clk or negedge aclr);
         if (!aclr) begin
            pos = -1; d = 8; mbusy = 0; mack = 0;
            q.delete();
         end else begin
            last   = (pos >= 0) && (pos == d - 1);
            apply  = mbusy && ((pos < 0) || last);
            accept = div_req && !mbusy && !mack;
            if ((pos < 0) || last) npos = en ? 0 : -1;
            else                   npos = pos + 1;
            if (apply) begin
               d = pend;
               mbusy = 0;
            end
            e.ack = accept;
            e.err = accept && (div_val < 2);
            if (accept && (div_val >= 2)) begin
               pend  = int'(div_val);
               mbusy = 1;
            end
            mack  = accept;
            pos   = npos;
            e.oc  = (pos >= 0) && (pos < (d + 1) / 2);
            e.tk  = (pos >= 0) && (pos == d - 1);
            e.bsy = mbusy;
            q.push_back(e);
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!aclr) begin
            chk("rst_outclock", outclock, 1'b0);
            chk("rst_tick", tick, 1'b0);
            chk("rst_ack", div_ack, 1'b0);
            chk("rst_err", div_err, 1'b0);
            chk("rst_busy", busy, 1'b0);
         end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("outclock", outclock, e.oc);
            chk("tick", tick, e.tk);
            chk("div_ack", div_ack, e.ack);
            chk("div_err", div_err, e.err);
            chk("busy", busy, e.bsy);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_req(input logic [15:0] v);
      bit got;
      got = 0;
      div_val = v;
      div_req = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (div_ack) begin
            got = 1;
            break;
         end
      end
      div_req = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL req_timeout got no ack expected ack for div_val %0d at %0t", v, $time);
      end
   endtask

   task automatic wait_tick();
      bit got;
      got = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (tick) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL tick_timeout got no tick expected tick at %0t", $time);
      end
   endtask

   initial begin : stim
      int hi, tk, r;
      repeat (3) @(posedge clk);
      #3 aclr = 1'b1;
      step(1);
      en = 1'b1;

      // First period at the default divisor: 4 high, 4 low, one tick.
      hi = 0; tk = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         hi += int'(outclock);
         tk += int'(tick);
      end
      chk_int("p8_high_cycles", hi, 4);
      chk_int("p8_tick_count", tk, 1);
      chk("p8_tick_last", tick, 1'b1);

      step(3);
      do_req(16'd5);
      step(20);
      do_req(16'd1);
      step(12);
      do_req(16'd8);
      do_req(16'd10);
      do_req(16'd4);
      step(40);
      do_req(16'd8);
      step(20);

      wait_tick();
      step(2);
      en = 1'b0;
      step(20);
      en = 1'b1;
      step(20);

      do_req(16'd12);
      step(3);
      @(posedge clk);
      #3 aclr = 1'b0;
      #1;
      chk("async_outclock", outclock, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_tick", tick, 1'b0);
      repeat (2) @(posedge clk);
      #3 aclr = 1'b1;
      step(30);

      for (int i = 0; i < 3000; i++) begin
         step(1);
         if ($urandom_range(15) == 0) en = ~en;
         if (!div_req) begin
            if ($urandom_range(5) == 0) begin
               div_req = 1'b1;
               r = int'($urandom_range(9));
               if (r == 0)      div_val = 16'd0;
               else if (r == 1) div_val = 16'd1;
               else             div_val = 16'($urandom_range(14, 2));
            end
         end else if (div_ack && ($urandom_range(3) != 0)) begin
            div_req = 1'b0;
         end
      end
      div_req = 1'b0;
      step(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
